// File: rtl/branch_target_unit_if.sv
// Operand/result bundle for branch_target_unit. With BTU_STATS_EN defined,
// the bundle also carries the saturating redirect/misalign counters.
//
// Handshake: in_valid qualifies the operands in the cycle it is high. There
// is no ready signal, so the producer must hold off while stall is high.
// out_valid qualifies target/redirect/misaligned/wrap. A result is consumed
// on the first rising edge where stall is low, and it is held stable while
// stall is high.
interface branch_target_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int IMM_W   = 16,
  parameter int INDEX_W = 26
);
  logic               in_valid;
  logic               stall;
  logic               flush;
  logic [1:0]         mode;
  logic [ADDR_W-1:0]  incr_pc;
  logic [IMM_W-1:0]   imm;
  logic [INDEX_W-1:0] instr_index;
  logic [ADDR_W-1:0]  reg_target;
  logic               cond_taken;
  logic               out_valid;
  logic [ADDR_W-1:0]  target;
  logic               redirect;
  logic               misaligned;
  logic               wrap;
`ifdef BTU_STATS_EN
  logic [15:0]        redirect_count;
  logic [15:0]        misalign_count;

  modport master (
    output in_valid, stall, flush, mode, incr_pc, imm, instr_index, reg_target, cond_taken,
    input  out_valid, target, redirect, misaligned, wrap, redirect_count, misalign_count
  );
  modport slave (
    input  in_valid, stall, flush, mode, incr_pc, imm, instr_index, reg_target, cond_taken,
    output out_valid, target, redirect, misaligned, wrap, redirect_count, misalign_count
  );
`else
  modport master (
    output in_valid, stall, flush, mode, incr_pc, imm, instr_index, reg_target, cond_taken,
    input  out_valid, target, redirect, misaligned, wrap
  );
  modport slave (
    input  in_valid, stall, flush, mode, incr_pc, imm, instr_index, reg_target, cond_taken,
    output out_valid, target, redirect, misaligned, wrap
  );
`endif
endinterface

// File: rtl/branch_target_unit.sv
// EX-stage next-PC target unit: computes branch, jump and jump-register targets
// with wrap/misalign flags through a 1- or 2-stage pipeline. Optional: BTU_STATS_EN.
module branch_target_unit #(
  parameter int ADDR_W      = 32,
  parameter int IMM_W       = 16,
  parameter int INDEX_W     = 26,
  parameter int PIPE_STAGES = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_target_unit_if.slave bus
);

  localparam int LO_W = ADDR_W / 2;
  localparam int HI_W = ADDR_W - LO_W;

  typedef enum logic [1:0] {
    MODE_BRANCH = 2'b00,
    MODE_JUMP   = 2'b01,
    MODE_JR     = 2'b10,
    MODE_RSVD   = 2'b11
  } modeT;

  // Stage 0: word offset and low half of the branch sum.
  logic [ADDR_W-1:0] offset0;
  logic [LO_W:0]     loSum0;

  assign offset0 = {{(ADDR_W-IMM_W-2){bus.imm[IMM_W-1]}}, bus.imm, 2'b00};
  assign loSum0  = {1'b0, bus.incr_pc[LO_W-1:0]} + {1'b0, offset0[LO_W-1:0]};

  // Operands seen by the finishing logic that feeds the output register.
  logic               finValid;
  modeT               finMode;
  logic [ADDR_W-1:0]  finIncrPc;
  logic [ADDR_W-1:0]  finRegTarget;
  logic [HI_W-1:0]    finOffsetHi;
  logic [LO_W-1:0]    finLoSum;
  logic               finLoCarry;
  logic [INDEX_W-1:0] finIndex;
  logic               finCond;

  generate
    if (PIPE_STAGES == 2) begin : gTwoStage
      logic               s1Valid;
      modeT               s1Mode;
      logic [ADDR_W-1:0]  s1IncrPc;
      logic [ADDR_W-1:0]  s1RegTarget;
      logic [HI_W-1:0]    s1OffsetHi;
      logic [LO_W-1:0]    s1LoSum;
      logic               s1LoCarry;
      logic [INDEX_W-1:0] s1Index;
      logic               s1Cond;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1Valid     <= 1'b0;
          s1Mode      <= MODE_BRANCH;
          s1IncrPc    <= '0;
          s1RegTarget <= '0;
          s1OffsetHi  <= '0;
          s1LoSum     <= '0;
          s1LoCarry   <= 1'b0;
          s1Index     <= '0;
          s1Cond      <= 1'b0;
        end else if (bus.flush) begin
          s1Valid <= 1'b0;
        end else if (!bus.stall) begin
          s1Valid <= bus.in_valid;
          if (bus.in_valid) begin
            s1Mode      <= modeT'(bus.mode);
            s1IncrPc    <= bus.incr_pc;
            s1RegTarget <= bus.reg_target;
            s1OffsetHi  <= offset0[ADDR_W-1:LO_W];
            s1LoSum     <= loSum0[LO_W-1:0];
            s1LoCarry   <= loSum0[LO_W];
            s1Index     <= bus.instr_index;
            s1Cond      <= bus.cond_taken;
          end
        end
      end

      assign finValid     = s1Valid;
      assign finMode      = s1Mode;
      assign finIncrPc    = s1IncrPc;
      assign finRegTarget = s1RegTarget;
      assign finOffsetHi  = s1OffsetHi;
      assign finLoSum     = s1LoSum;
      assign finLoCarry   = s1LoCarry;
      assign finIndex     = s1Index;
      assign finCond      = s1Cond;
    end else begin : gOneStage
      assign finValid     = bus.in_valid;
      assign finMode      = modeT'(bus.mode);
      assign finIncrPc    = bus.incr_pc;
      assign finRegTarget = bus.reg_target;
      assign finOffsetHi  = offset0[ADDR_W-1:LO_W];
      assign finLoSum     = loSum0[LO_W-1:0];
      assign finLoCarry   = loSum0[LO_W];
      assign finIndex     = bus.instr_index;
      assign finCond      = bus.cond_taken;
    end
  endgenerate

  // High half of the branch sum; its carry-out decides wrap with the offset sign.
  logic [HI_W:0]       hiSum;
  logic [ADDR_W-1:0]   jumpTarget;
  logic [ADDR_W-1:0]   nextTarget;
  logic                nextRedirect;
  logic                nextMis;
  logic                nextWrap;

  assign hiSum = {1'b0, finIncrPc[ADDR_W-1:LO_W]} + {1'b0, finOffsetHi}
               + {{HI_W{1'b0}}, finLoCarry};
  assign jumpTarget = (finIncrPc & ~ADDR_W'({(INDEX_W+2){1'b1}}))
                    | ADDR_W'({finIndex, 2'b00});

  always_comb begin
    nextTarget   = finIncrPc;
    nextRedirect = 1'b0;
    nextMis      = 1'b0;
    nextWrap     = 1'b0;
    case (finMode)
      MODE_BRANCH: begin
        nextTarget   = {hiSum[HI_W-1:0], finLoSum};
        nextWrap     = finOffsetHi[HI_W-1] ? ~hiSum[HI_W] : hiSum[HI_W];
        nextRedirect = finCond;
      end
      MODE_JUMP: begin
        nextTarget   = jumpTarget;
        nextRedirect = 1'b1;
      end
      MODE_JR: begin
        nextTarget   = finRegTarget;
        nextMis      = |finRegTarget[1:0];
        nextRedirect = ~(|finRegTarget[1:0]);
      end
      default: ;
    endcase
  end

  // Output register; target keeps its last value when no result is loaded.
  logic              outValidR;
  logic [ADDR_W-1:0] targetR;
  logic              redirectR;
  logic              misR;
  logic              wrapR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValidR <= 1'b0;
      targetR   <= '0;
      redirectR <= 1'b0;
      misR      <= 1'b0;
      wrapR     <= 1'b0;
    end else if (bus.flush) begin
      outValidR <= 1'b0;
    end else if (!bus.stall) begin
      outValidR <= finValid;
      if (finValid) begin
        targetR   <= nextTarget;
        redirectR <= nextRedirect;
        misR      <= nextMis;
        wrapR     <= nextWrap;
      end
    end
  end

  assign bus.out_valid  = outValidR;
  assign bus.target     = targetR;
  assign bus.redirect   = outValidR & redirectR;
  assign bus.misaligned = outValidR & misR;
  assign bus.wrap       = outValidR & wrapR;

`ifdef BTU_STATS_EN
  logic [15:0] redirectCnt;
  logic [15:0] misalignCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirectCnt <= '0;
      misalignCnt <= '0;
    end else if (!bus.stall) begin
      if (bus.redirect && (redirectCnt != 16'hFFFF)) redirectCnt <= redirectCnt + 16'd1;
      if (bus.misaligned && (misalignCnt != 16'hFFFF)) misalignCnt <= misalignCnt + 16'd1;
    end
  end

  assign bus.redirect_count = redirectCnt;
  assign bus.misalign_count = misalignCnt;
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
// Bench for branch_target_unit: PIPE_STAGES=1 and =2 instances driven in lockstep,
// with a scoreboard queue per instance. Define BTU_STATS_EN to cover the counters.
module tb_branch_target_unit;
  localparam int AW = 32;
  localparam int IW = 16;
  localparam int XW = 26;
  localparam int EW = 67;  // {due cycle[31:0], target[31:0], redirect, misaligned, wrap}

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          inValid = 1'b0, stallS = 1'b0, flushS = 1'b0, condS = 1'b0;
  logic [1:0]    modeS = '0;
  logic [AW-1:0] incrS = '0, rtS = '0;
  logic [IW-1:0] immS = '0;
  logic [XW-1:0] idxS = '0;

  branch_target_unit_if #(.ADDR_W(AW), .IMM_W(IW), .INDEX_W(XW)) bus1 ();
  branch_target_unit_if #(.ADDR_W(AW), .IMM_W(IW), .INDEX_W(XW)) bus2 ();

  assign bus1.in_valid = inValid;     assign bus2.in_valid = inValid;
  assign bus1.stall = stallS;         assign bus2.stall = stallS;
  assign bus1.flush = flushS;         assign bus2.flush = flushS;
  assign bus1.mode = modeS;           assign bus2.mode = modeS;
  assign bus1.incr_pc = incrS;        assign bus2.incr_pc = incrS;
  assign bus1.imm = immS;             assign bus2.imm = immS;
  assign bus1.instr_index = idxS;     assign bus2.instr_index = idxS;
  assign bus1.reg_target = rtS;       assign bus2.reg_target = rtS;
  assign bus1.cond_taken = condS;     assign bus2.cond_taken = condS;

  branch_target_unit #(.ADDR_W(AW), .IMM_W(IW), .INDEX_W(XW), .PIPE_STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  branch_target_unit #(.ADDR_W(AW), .IMM_W(IW), .INDEX_W(XW), .PIPE_STAGES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  logic          ov [2];
  logic [AW-1:0] tg [2];
  logic          rd [2], ms [2], wr [2];
  assign ov[0] = bus1.out_valid;  assign ov[1] = bus2.out_valid;
  assign tg[0] = bus1.target;     assign tg[1] = bus2.target;
  assign rd[0] = bus1.redirect;   assign rd[1] = bus2.redirect;
  assign ms[0] = bus1.misaligned; assign ms[1] = bus2.misaligned;
  assign wr[0] = bus1.wrap;       assign wr[1] = bus2.wrap;

  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];
  int nVec = 0;
  int nMis = 0;

  // Cycle counter that advances only on edges where the pipeline moves.
  logic [31:0] ecyc = '0;
  logic [31:0] lastE = '0;
  always @(posedge clk) if (rst_n && (!stallS || flushS)) ecyc <= ecyc + 32'd1;

  // Reference model, written with 64-bit signed arithmetic.
  function automatic logic [34:0] model(input logic [1:0] m, input logic [AW-1:0] pc,
                                        input logic [IW-1:0] im, input logic [XW-1:0] ix,
                                        input logic [AW-1:0] rt, input logic c);
    longint s;
    logic [AW-1:0] t;
    logic red, mis, w;
    s = longint'(pc) + longint'($signed(im)) * 4;
    t = pc; red = 1'b0; mis = 1'b0; w = 1'b0;
    case (m)
      2'b00: begin t = s[31:0]; w = (s < 0) || (s > 64'sd4294967295); red = c; end
      2'b01: begin t = {pc[31:28], ix, 2'b00}; red = 1'b1; end
      2'b10: begin t = rt; mis = (rt[1:0] != 2'b00); red = !mis; end
      default: ;
    endcase
    return {t, red, mis, w};
  endfunction

  // Scoreboard monitor: pops on every advancing edge, checks hold during stalls.
  logic          snapV [2];
  logic          snapO [2], snapR [2];
  logic [AW-1:0] snapT [2];
  initial begin snapV[0] = 1'b0; snapV[1] = 1'b0; end

  always @(negedge clk) begin
    logic adv;
    logic [EW-1:0] e;
    adv = (ecyc != lastE);
    lastE = ecyc;
    if (!rst_n) begin
      snapV[0] = 1'b0; snapV[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (adv) begin
          nVec++;
          if (ov[d]) begin
            if (((d == 0) ? q0.size() : q1.size()) == 0) begin
              nMis++;
              $display("FAIL spurious_out dut%0d cyc=%0d got target=%h, want no output", d, ecyc, tg[d]);
            end else begin
              e = (d == 0) ? q0.pop_front() : q1.pop_front();
              if ({ecyc, tg[d], rd[d], ms[d], wr[d]} !== e) begin
                nMis++;
                $display("FAIL result dut%0d got cyc=%0d t=%h rmw=%b%b%b want cyc=%0d t=%h rmw=%b",
                         d, ecyc, tg[d], rd[d], ms[d], wr[d], e[66:35], e[34:3], e[2:0]);
              end
            end
          end else if ({rd[d], ms[d], wr[d]} !== 3'b000) begin
            nMis++;
            $display("FAIL idle_flags dut%0d got rmw=%b%b%b want 000", d, rd[d], ms[d], wr[d]);
          end
          snapV[d] = 1'b1; snapO[d] = ov[d]; snapR[d] = rd[d]; snapT[d] = tg[d];
        end else if (snapV[d]) begin
          nVec++;
          if ({ov[d], rd[d], tg[d]} !== {snapO[d], snapR[d], snapT[d]}) begin
            nMis++;
            $display("FAIL stall_hold dut%0d got v=%b r=%b t=%h want v=%b r=%b t=%h",
                     d, ov[d], rd[d], tg[d], snapO[d], snapR[d], snapT[d]);
          end
        end
      end
    end
  end

  task automatic drive(input logic [1:0] m, input logic [AW-1:0] pc, input logic [IW-1:0] im,
                       input logic [XW-1:0] ix, input logic [AW-1:0] rt, input logic c);
    logic [34:0] x;
    modeS = m; incrS = pc; immS = im; idxS = ix; rtS = rt; condS = c; inValid = 1'b1;
    if (!stallS && !flushS) begin
      x = model(m, pc, im, ix, rt, c);
      q0.push_back({ecyc + 32'd1, x});
      q1.push_back({ecyc + 32'd2, x});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    inValid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    drive(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC, 16'($urandom),
          26'($urandom), $urandom, 1'($urandom));
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      nVec++;
      if ({ov[d], rd[d], ms[d], wr[d], tg[d]} !== '0) begin
        nMis++;
        $display("FAIL reset_state dut%0d got v=%b r=%b m=%b w=%b t=%h want all zero",
                 d, ov[d], rd[d], ms[d], wr[d], tg[d]);
      end
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_branch();
    drive(2'b00, 32'h0040_0004, 16'h0003, '0, '0, 1'b1);
    nVec++;
    if ({tg[0], rd[0], wr[0]} !== {32'h0040_0010, 1'b1, 1'b0}) begin
      nMis++;
      $display("FAIL fwd_branch got t=%h r=%b w=%b want t=00400010 r=1 w=0", tg[0], rd[0], wr[0]);
    end
    drive(2'b00, 32'h0000_0004, 16'hFFFE, '0, '0, 1'b1);
    nVec++;
    if ({tg[0], rd[0], wr[0]} !== {32'hFFFF_FFFC, 1'b1, 1'b1}) begin
      nMis++;
      $display("FAIL back_wrap got t=%h r=%b w=%b want t=fffffffc r=1 w=1", tg[0], rd[0], wr[0]);
    end
    drive(2'b00, 32'h0000_0004, 16'hFFFE, '0, '0, 1'b0);
    nVec++;
    if ({tg[0], rd[0], wr[0]} !== {32'hFFFF_FFFC, 1'b0, 1'b1}) begin
      nMis++;
      $display("FAIL not_taken got t=%h r=%b w=%b want t=fffffffc r=0 w=1", tg[0], rd[0], wr[0]);
    end
    drive(2'b00, 32'hFFFF_FFF0, 16'h0008, '0, '0, 1'b1);  // forward carry-out
    drive(2'b00, 32'h0000_8000, 16'h8000, '0, '0, 1'b1);  // most negative offset
    idle(3);
  endtask

  task automatic test_jump();
    drive(2'b01, 32'hA000_0008, '0, 26'h000_0100, '0, 1'b0);
    nVec++;
    if ({tg[0], rd[0]} !== {32'hA000_0400, 1'b1}) begin
      nMis++;
      $display("FAIL jump got t=%h r=%b want t=a0000400 r=1", tg[0], rd[0]);
    end
    drive(2'b10, '0, '0, '0, 32'h0040_0006, 1'b1);
    nVec++;
    if ({ms[0], rd[0]} !== 2'b10) begin
      nMis++;
      $display("FAIL jr_misaligned got m=%b r=%b want m=1 r=0", ms[0], rd[0]);
    end
    drive(2'b10, '0, '0, '0, 32'h8000_1000, 1'b0);
    drive(2'b11, 32'h1234_5678, 16'hFFFF, 26'h3FF_FFFF, 32'hFFFF_FFFF, 1'b1);
    nVec++;
    if ({tg[0], rd[0], ms[0], wr[0]} !== {32'h1234_5678, 3'b000}) begin
      nMis++;
      $display("FAIL reserved got t=%h rmw=%b%b%b want t=12345678 rmw=000", tg[0], rd[0], ms[0], wr[0]);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    drive(2'b00, 32'h0000_1000, 16'h0010, '0, '0, 1'b1);
    drive(2'b01, 32'h4000_0000, '0, 26'h123_4567, '0, 1'b0);
    drive(2'b10, '0, '0, '0, 32'h0000_2000, 1'b0);
    for (int i = 0; i < 24; i++) drive_random();
    idle(4);
  endtask

  task automatic test_stall();
    drive(2'b00, 32'h0000_0100, 16'h0001, '0, '0, 1'b1);
    drive(2'b01, 32'h8000_0000, '0, 26'h000_0042, '0, 1'b0);
    stallS = 1'b1;
    drive(2'b10, '0, '0, '0, 32'h0000_0003, 1'b0);  // ignored while stalled
    drive(2'b10, '0, '0, '0, 32'h0000_0001, 1'b0);
    stallS = 1'b0;
    drive(2'b10, '0, '0, '0, 32'h0000_0800, 1'b0);
    drive_random();
    idle(4);
  endtask

  task automatic test_flush();
    logic [AW-1:0] cap0, cap1;
    drive(2'b00, 32'h0000_0200, 16'h0004, '0, '0, 1'b1);
    drive(2'b01, 32'h2000_0000, '0, 26'h000_0011, '0, 1'b0);
    while (q0.size() > 0 && q0[q0.size()-1][66:35] > ecyc) void'(q0.pop_back());
    while (q1.size() > 0 && q1[q1.size()-1][66:35] > ecyc) void'(q1.pop_back());
    cap0 = tg[0];
    cap1 = tg[1];
    flushS = 1'b1;
    stallS = 1'b1;
    drive(2'b01, 32'hF000_0000, '0, 26'h3FF_FFFF, '0, 1'b1);
    flushS = 1'b0;
    stallS = 1'b0;
    nVec++;
    if ({ov[0], ov[1], rd[0], rd[1]} !== 4'b0000) begin
      nMis++;
      $display("FAIL flush_valid got v=%b%b r=%b%b want v=00 r=00", ov[0], ov[1], rd[0], rd[1]);
    end
    nVec++;
    if ({tg[0], tg[1]} !== {cap0, cap1}) begin
      nMis++;
      $display("FAIL flush_target got %h %h want %h %h", tg[0], tg[1], cap0, cap1);
    end
    idle(4);
  endtask

  task automatic test_async_reset();
    drive(2'b00, 32'h0000_0300, 16'h0002, '0, '0, 1'b1);
    drive(2'b01, 32'h3000_0000, '0, 26'h000_0021, '0, 1'b0);
    drive(2'b10, '0, '0, '0, 32'h0000_4000, 1'b0);
    #1;
    nVec++;
    if ({ov[0], ov[1]} !== 2'b11) begin
      nMis++;
      $display("FAIL pre_reset_valid got %b%b want 11", ov[0], ov[1]);
    end
    rst_n = 1'b0;
    #1;
    nVec++;
    if ({ov[0], ov[1], rd[0], rd[1], tg[0], tg[1]} !== '0) begin
      nMis++;
      $display("FAIL async_reset got v=%b%b r=%b%b t=%h %h want all zero",
               ov[0], ov[1], rd[0], rd[1], tg[0], tg[1]);
    end
    q0.delete();
    q1.delete();
    inValid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
  endtask

`ifdef BTU_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) drive(2'b00, 32'h0010_0000, 16'($urandom), '0, '0, 1'b1);
    idle(4);
    nVec++;
    if ({bus1.redirect_count, bus2.redirect_count} !== {16'd100, 16'd100}) begin
      nMis++;
      $display("FAIL redirect_count got %0d %0d want 100", bus1.redirect_count, bus2.redirect_count);
    end
    drive(2'b10, '0, '0, '0, 32'h0000_0102, 1'b1);
    idle(4);
    nVec++;
    if ({bus1.misalign_count, bus2.misalign_count, bus1.redirect_count, bus2.redirect_count}
        !== {16'd1, 16'd1, 16'd100, 16'd100}) begin
      nMis++;
      $display("FAIL misalign_count got m=%0d %0d r=%0d %0d want m=1 r=100", bus1.misalign_count,
               bus2.misalign_count, bus1.redirect_count, bus2.redirect_count);
    end
    for (int i = 0; i < 70000; i++) drive(2'b00, 32'h0010_0000, 16'($urandom), '0, '0, 1'b1);
    drive(2'b10, '0, '0, '0, 32'h0000_0101, 1'b1);
    idle(4);
    nVec++;
    if ({bus1.redirect_count, bus2.redirect_count, bus1.misalign_count, bus2.misalign_count}
        !== {16'hFFFF, 16'hFFFF, 16'd2, 16'd2}) begin
      nMis++;
      $display("FAIL count_saturate got r=%h %h m=%0d %0d want r=ffff m=2", bus1.redirect_count,
               bus2.redirect_count, bus1.misalign_count, bus2.misalign_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
`ifdef BTU_STATS_EN
    test_stats();
`endif
    nVec++;
    if ((q0.size() != 0) || (q1.size() != 0)) begin
      nMis++;
      $display("FAIL drain got %0d %0d results outstanding want 0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
Parametrised EX-stage successor to the single-adder branch target calculation. Computes the next-PC target for PC-relative branches, absolute jumps and jump-register, then flags misaligned targets and address wrap-around. Results are registered through a 1- or 2-stage pipeline with stall and flush control. The unit drives the fetch-stage redirect.

Parameters:
ADDR_W, 32, PC/address width in bits
IMM_W, 16, branch immediate width; sign-extended, then shifted left by 2
INDEX_W, 26, jump instruction-index width; constraint ADDR_W >= INDEX_W+2
PIPE_STAGES, 1, register stages (legal values 1 or 2); equals output latency in cycles

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid this cycle
stall  input  1  hold all stages
flush  input  1  kill all in-flight entries
mode  input  2  00 branch-relative, 01 jump-absolute, 10 jump-register, 11 reserved
incr_pc  input  ADDR_W  PC+4 of the branch/jump
imm  input  IMM_W  raw branch offset, in words
instr_index  input  INDEX_W  J-type target field
reg_target  input  ADDR_W  rs value for jump-register
cond_taken  input  1  branch condition result (used only when mode=00)
out_valid  output  1  result valid
target  output  ADDR_W  computed target
redirect  output  1  fetch must load target
misaligned  output  1  target[1:0]!=0
wrap  output  1  branch target wrapped modulo 2^ADDR_W

Behaviour:
- Reset (async, rst_n=0): all pipeline valid bits and all outputs are 0 immediately. Release is synchronous to clk.
- Target computation by mode:
  - mode 00: target = (incr_pc + (sext(imm) << 2)) mod 2^ADDR_W.
  - mode 01: target = {incr_pc[ADDR_W-1:INDEX_W+2], instr_index, 2'b00}.
  - mode 10: target = reg_target.
  - mode 11: target = incr_pc; redirect=0; misaligned=0; wrap=0.
- wrap (mode 00 only):
  - Set when offset >= 0 and the unsigned add carries out of bit ADDR_W-1.
  - Set when offset < 0 and the add has no carry (underflow).
  - Otherwise 0.
- misaligned: target[1:0]!=0. Only mode 10 can assert it.
- redirect = out_valid & ~misaligned & ((mode==00 & cond_taken) | mode==01 | mode==10).
- Latency: the result of an accepted input appears exactly PIPE_STAGES cycles later, with stall=0 throughout.
  - PIPE_STAGES=2: stage 1 registers the operands and the low ADDR_W/2 bits of the sum plus its carry. Stage 2 completes the high half, wrap, misaligned and redirect.
- Throughput: one input per cycle. There is no backpressure output; the upstream stage must honour stall itself.
- stall=1: every stage register holds its value. Outputs stay stable. in_valid is ignored, and no bubble is inserted.
- flush=1: all stage valid bits clear on the next edge. out_valid and redirect become 0 the following cycle; target holds its last value.
- Priority: flush over stall over in_valid. flush and in_valid together drop the input.
- Outputs are 0 whenever out_valid=0, except target, which holds.
- reset asserted mid-operation: in-flight entries are discarded with no partial output.

Optional Feature:
BTU_STATS_EN
- Defined: adds outputs redirect_count[15:0] and misalign_count[15:0].
  - redirect_count increments on each cycle with redirect=1 and stall=0.
  - misalign_count increments on each cycle with out_valid & misaligned and stall=0.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Forward branch, PIPE_STAGES=1: mode=00, incr_pc=0x00400004, imm=0x0003, cond_taken=1 -> next cycle target=0x00400010, redirect=1, wrap=0.
- Backward/wrap: incr_pc=0x00000004, imm=0xFFFE -> target=0xFFFFFFFC, wrap=1. Same operands with cond_taken=0 -> redirect=0, target still 0xFFFFFFFC.
- Jump and JR: mode=01, incr_pc=0xA0000008, instr_index=0x0000100 -> target=0xA0000400, redirect=1. mode=10, reg_target=0x00400006 -> misaligned=1, redirect=0.
- PIPE_STAGES=2 back-to-back: three inputs on consecutive cycles -> three results on cycles +2, +3, +4 in order. A 2-cycle stall mid-stream holds all outputs and delays each result by 2.
- Flush/stall priority: flush=1, stall=1, in_valid=1 in the same cycle -> out_valid=0 next cycle and nothing emerges later. Async rst_n pulse mid-stream -> out_valid drops without waiting for clk.
- BTU_STATS_EN: 70000 taken branches -> redirect_count=0xFFFF (saturated). Misaligned JR -> misalign_count increments by 1 and redirect_count is unchanged.
